lc3_mem_arbiter: RTL and testbench

//  Shares the single-port LC-3 main memory (async-read spo, sync-write we) between two requesters:
//  the LC-3 core (fetch/load/store) and the console loader (SW/BTN entry, cursor readback).

---
 rtl/lc3_pkg.sv | 10 +
 rtl/lc3_rr_pick.sv | 23 ++
 rtl/lc3_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types and default sizes for the LC-3 memory arbiter slice.
package lc3_pkg;

  localparam int LC3_ADDR_W = 10;
  localparam int LC3_DATA_W = 16;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
  typedef enum logic       {REQ_CORE, REQ_CON} req_id_t;

endpackage

// File: rtl/lc3_rr_pick.sv
// Two-way round-robin picker: a lone requester wins; on a tie the requester
// that did not win last time gets the grant.
module lc3_rr_pick
  import lc3_pkg::*;
(
  input  logic    core_req,
  input  logic    con_req,
  input  req_id_t last_grant,
  output logic    valid,
  output req_id_t winner
);

  // Tie-break flips away from the previous winner.
  always_comb begin
    valid  = core_req | con_req;
    winner = REQ_CORE;
    if (core_req && con_req)
      winner = (last_grant == REQ_CORE) ? REQ_CON : REQ_CORE;
    else if (con_req)
      winner = REQ_CON;
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates the single-port LC-3 main memory between the core and the console
// loader. One access per three cycles: IDLE (pick + register request),
// ACCESS (memory write / read capture), DONE (ack to the winner).
// Optional feature: define LC3_ARB_PERF_EN to add the perf_wait console stall counter.
module lc3_mem_arbiter
  import lc3_pkg::*;
#(
  parameter int ADDR_W = LC3_ADDR_W,
  parameter int DATA_W = LC3_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  input  logic              con_req,
  input  logic              con_we,
  input  logic [ADDR_W-1:0] con_addr,
  input  logic [DATA_W-1:0] con_wdata,
  output logic              con_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo,
  output logic              busy
`ifdef LC3_ARB_PERF_EN
  ,
  output logic [15:0]       perf_wait
`endif
);

  arb_state_t        state, state_nxt;
  req_id_t           grant, last_grant;
  logic              pick_vld;
  req_id_t           pick_win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  lc3_rr_pick u_pick (
    .core_req   (core_req),
    .con_req    (con_req),
    .last_grant (last_grant),
    .valid      (pick_vld),
    .winner     (pick_win)
  );

  // Route the winning requester's command towards the memory registers.
  always_comb begin
    sel_we    = core_we;
    sel_addr  = core_addr;
    sel_wdata = core_wdata;
    if (pick_win == REQ_CON) begin
      sel_we    = con_we;
      sel_addr  = con_addr;
      sel_wdata = con_wdata;
    end
  end

  // Next-state logic; requests only matter in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:   if (pick_vld) state_nxt = ARB_ACCESS;
      ARB_ACCESS: state_nxt = ARB_DONE;
      ARB_DONE:   state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // State, grant bookkeeping and the registered memory interface.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ARB_IDLE;
      grant      <= REQ_CON;
      last_grant <= REQ_CON;
      mem_a      <= '0;
      mem_d      <= '0;
      mem_we     <= 1'b0;
      rd_data    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant  <= pick_win;
            mem_a  <= sel_addr;
            mem_d  <= sel_wdata;
            mem_we <= sel_we;
          end
        end
        ARB_ACCESS: begin
          // The memory commits a write on this same edge; reads capture spo.
          mem_we <= 1'b0;
          if (!mem_we) rd_data <= mem_spo;
        end
        ARB_DONE: last_grant <= grant;
        default: ;
      endcase
    end
  end

  assign core_ack = (state == ARB_DONE) && (grant == REQ_CORE);
  assign con_ack  = (state == ARB_DONE) && (grant == REQ_CON);
  assign busy     = (state != ARB_IDLE);

`ifdef LC3_ARB_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count cycles the console is asking but not being acknowledged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     perf_wait <= 16'd0;
    else if (con_req && !con_ack) perf_wait <= sat_inc16(perf_wait);
  end
`endif

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter with a behavioural async-read memory.
module tb_lc3_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        core_req, core_we, con_req, con_we;
  logic [9:0]  core_addr, con_addr, mem_a;
  logic [15:0] core_wdata, con_wdata, rd_data, mem_d, mem_spo;
  logic        core_ack, con_ack, mem_we, busy;
`ifdef LC3_ARB_PERF_EN
  logic [15:0] perf_wait;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:1023];
  assign mem_spo = mem[mem_a];
  always @(posedge CLK) if (mem_we) mem[mem_a] <= mem_d;

  always #5 CLK = ~CLK;

  lc3_mem_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack),
    .con_req(con_req), .con_we(con_we), .con_addr(con_addr),
    .con_wdata(con_wdata), .con_ack(con_ack),
    .rd_data(rd_data), .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
    .mem_spo(mem_spo), .busy(busy)
`ifdef LC3_ARB_PERF_EN
    , .perf_wait(perf_wait)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          is_con;
    bit          we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  // Full single-requester transaction starting just after a clock edge in IDLE.
  task automatic txn(input vec_t v, input string nm);
    if (v.is_con) begin
      con_req = 1; con_we = v.we; con_addr = v.addr; con_wdata = v.wdata;
    end else begin
      core_req = 1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata;
    end
    @(posedge CLK); #1;
    chk({nm, ".acc_busy"}, busy, 1);
    chk({nm, ".acc_we"}, mem_we, v.we);
    chk({nm, ".acc_a"}, mem_a, v.addr);
    if (v.we) chk({nm, ".acc_d"}, mem_d, v.wdata);
    chk({nm, ".acc_acks"}, {core_ack, con_ack}, 2'b00);
    @(posedge CLK); #1;
    chk({nm, ".done_acks"}, {core_ack, con_ack}, v.is_con ? 2'b01 : 2'b10);
    chk({nm, ".done_we"}, mem_we, 0);
    chk({nm, ".rd"}, rd_data, v.exp_rd);
    core_req = 0; con_req = 0;
    @(posedge CLK); #1;
    chk({nm, ".idle"}, {busy, core_ack, con_ack}, 3'b000);
  endtask

  task automatic do_reset();
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    RST = 1; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    con_req = 0; con_we = 0; con_addr = '0; con_wdata = '0;

    vecs[0] = '{1'b1, 1'b1, 10'h005, 16'h1234, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 10'h005, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 10'h3FF, 16'hBEEF, 16'h1234};
    vecs[3] = '{1'b0, 1'b0, 10'h3FF, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b1, 10'h000, 16'hA5A5, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 10'h000, 16'h0000, 16'hA5A5};
    vecs[6] = '{1'b1, 1'b1, 10'h005, 16'h0F0F, 16'hA5A5};
    vecs[7] = '{1'b0, 1'b0, 10'h005, 16'h0000, 16'h0F0F};

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outs", {core_ack, con_ack, mem_we, busy, rd_data, mem_a, mem_d}, '0);
    RST = 0;

    for (int i = 0; i < 8; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a core read.
    core_req = 1; core_we = 0; core_addr = 10'h3FF;
    @(posedge CLK); #1;
    RST = 1; #1;
    chk("rst_mid_outs", {core_ack, con_ack, mem_we, busy}, 4'b0000);
    chk("rst_mid_data", {rd_data, mem_a, mem_d}, '0);
    core_req = 0;
    @(posedge CLK); #1;
    RST = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("rst_idle%0d", k), {core_ack, con_ack, busy, mem_we}, 4'b0000);
    end

    // Contention right after reset: core takes the first tie, then alternation.
    core_req = 1; core_we = 0; core_addr = 10'h005;
    con_req  = 1; con_we  = 0; con_addr  = 10'h3FF;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("cont_core_ack%0d", k), core_ack, (k == 2 || k == 8));
      chk($sformatf("cont_con_ack%0d", k), con_ack, (k == 5));
      if (k == 2) chk("cont_rd_core", rd_data, 16'h0F0F);
      if (k == 5) chk("cont_rd_con", rd_data, 16'hBEEF);
    end
    core_req = 0; con_req = 0;
    @(posedge CLK); #1;

    // Reset lands during ACCESS of a console write; the write must not commit.
    con_req = 1; con_we = 1; con_addr = 10'h010; con_wdata = 16'hDEAD;
    @(posedge CLK); #1;
    chk("abort_we_before", mem_we, 1);
    #2 RST = 1; #1;
    chk("abort_we_drop", mem_we, 0);
    chk("abort_no_ack", con_ack, 0);
    con_req = 0;
    @(posedge CLK); #1;
    chk("abort_no_ack2", con_ack, 0);
    RST = 0;
    chk("abort_mem", mem[16], 16'h0000);
    txn('{1'b1, 1'b0, 10'h010, 16'h0000, 16'h0000}, "abort_readback");

`ifdef LC3_ARB_PERF_EN
    do_reset();
    chk("perf_zero", perf_wait, 0);
    core_req = 1; core_we = 0; core_addr = 10'h005;
    con_req  = 1; con_we  = 0; con_addr  = 10'h005;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("perf_cnt%0d", k), perf_wait, (k < 6) ? k : 5);
    end
    con_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("perf_frozen%0d", k), perf_wait, 5);
    end
    core_req = 0;
    repeat (3) @(posedge CLK);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
